// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the mux_rr_stream stream multiplexer.
//   mode_e     : run-time selection mode encodings
//   MAX_CH     : upper bound on channel count supported by the search helper
//   first_from : index of the first set request bit, searching upward from a
//                start offset and wrapping at n-1 -> 0; -1 when none is set
package mux_pkg;

  typedef enum logic [1:0] {
    MODE_SEL  = 2'b00,
    MODE_PRIO = 2'b01,
    MODE_RR   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int MAX_CH   = 32;
  localparam int MAX_CH_W = 5;

  // The loop runs downward so that the last hit written is the one closest
  // to the start offset, which is the winner.
  function automatic int first_from(input logic [MAX_CH-1:0] req,
                                    input int n,
                                    input int start);
    int res;
    int idx;
    res = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (start + k) % n;
        if (req[idx[MAX_CH_W-1:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant logic for mux_rr_stream.
//   req       in  N_CH  request vector (channel valids)
//   start     in  SELW  MODE_SEL: selected channel; MODE_RR: search start
//   mode      in  2     selection mode (mux_pkg::mode_e encoding)
//   grant     out N_CH  one-hot grant, or zero when nothing is granted
//   grant_idx out SELW  index of the granted channel (0 when no grant)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] start,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] grant,
  output logic [SELW-1:0] grant_idx
);

  logic [MAX_CH-1:0] req_ext;
  int                hit;

  assign req_ext = MAX_CH'(req);

  always_comb begin
    hit       = -1;
    grant     = '0;
    grant_idx = '0;

    case (mode_e'(mode))
      // An out-of-range select (possible when N_CH is not a power of two)
      // simply yields no grant.
      MODE_SEL: begin
        if (int'(start) < N_CH) begin
          if (req_ext[int'(start)]) hit = int'(start);
        end
      end
      MODE_RR:  hit = first_from(req_ext, N_CH, int'(start));
      default:  hit = first_from(req_ext, N_CH, 0);
    endcase

    for (int i = 0; i < N_CH; i++) begin
      if (hit == i) grant[i] = 1'b1;
    end
    if (hit >= 0) grant_idx = SELW'(hit);
  end

endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N_CH-channel, W-bit valid/ready stream multiplexer with a
// registered output stage and run-time selectable arbitration.
//   clk       in  1          rising-edge clock
//   rst_n     in  1          asynchronous active-low reset
//   mode      in  2          00 external sel, 01 fixed priority, 10 round-robin,
//                            11 behaves as 01
//   sel       in  SELW       channel index used in mode 00
//   in_data   in  N_CH*W     channel i at [i*W +: W]
//   in_valid  in  N_CH       per-channel valid
//   in_ready  out N_CH       per-channel ready (combinational, zero in reset)
//   out_data  out W          registered data
//   out_chan  out SELW       registered source channel index
//   out_valid out 1          registered valid
//   out_ready in  1          consumer ready
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [SELW-1:0]     sel,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_valid,
  output logic [N_CH-1:0]     in_ready,
  output logic [W-1:0]        out_data,
  output logic [SELW-1:0]     out_chan,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_chan_q,  out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

  logic [N_CH-1:0] grant;
  logic [SELW-1:0] grant_idx;
  logic [SELW-1:0] arb_start;
  logic [W-1:0]    grant_data;
  logic            accept;
  logic            transfer;

  // The arbiter's start input doubles as the external select in mode 00.
  assign arb_start = (mode_e'(mode) == MODE_SEL) ? sel : rr_ptr_q;

  rr_arbiter #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .start     (arb_start),
    .mode      (mode),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = !out_valid_q || out_ready;

  // Gating with rst_n keeps producers from seeing a ready while in reset.
  assign in_ready = rst_n ? (grant & {N_CH{accept}}) : '0;

  // A grant implies the matching valid, so any ready bit is a transfer.
  assign transfer = |in_ready;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) grant_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;

    if (accept) begin
      if (transfer) begin
        out_data_d  = grant_data;
        out_chan_d  = grant_idx;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (transfer && (mode_e'(mode) == MODE_RR)) begin
      if (grant_idx == SELW'(N_CH - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
